nested_loop_cfg_ctrl: RTL
=========================

// Module: nested_loop_cfg_ctrl
// PURPOSE
//  Upstream control stage for the SIMD nested-loop address generator. Accepts loop
//  configuration ops (base, per-level iteration count, per-level stride, start) over a
//  valid/ready port and holds them in registers that drive the generator's
//  base/stride/num_iter buses. On START it pulses start_loop, holds in_nested_loop
//  high, counts the generated addresses, and waits for loop_done. It then reports
//  completion, or a timeout error.
// PARAMETERS
//  NUM_MAX_LOOPS     7         loop levels; level 0 outermost, NUM_MAX_LOOPS-1 innermost
//  LOG_NUM_MAX_LOOPS 3         width of cfg_level
//  BASE_WIDTH        32        base/cfg_value width
//  STRIDE_WIDTH      32        per-level stride width
//  NUM_ITER_WIDTH    32        per-level iteration-count width; also address-count width
//  TIMEOUT_CYCLES    1048576   RUN cycles allowed without loop_done before error
// PORTS
//  clk            in   1                          clock
//  reset          in   1                          synchronous, active-high
//  cfg_valid      in   1                          op offered
//  cfg_ready      out  1                          op accepted when cfg_valid&&cfg_ready
//  cfg_op         in   2                          0 SET_BASE, 1 SET_ITER, 2 SET_STRIDE, 3 START
//  cfg_level      in   LOG_NUM_MAX_LOOPS          target level for SET_ITER/SET_STRIDE
//  cfg_value      in   BASE_WIDTH                 immediate, truncated to field width
//  base           out  BASE_WIDTH                 to generator
//  stride         out  STRIDE_WIDTH*NUM_MAX_LOOPS level i at [i*STRIDE_WIDTH +: STRIDE_WIDTH]
//  num_iter       out  NUM_ITER_WIDTH*NUM_MAX_LOOPS level i at [i*NUM_ITER_WIDTH +: NUM_ITER_WIDTH]
//  start_loop     out  1                          one-cycle pulse to generator
//  in_nested_loop out  1                          high while a loop runs
//  address_valid  in   1                          from generator
//  loop_done      in   1                          from generator
//  addr_count     out  NUM_ITER_WIDTH             address_valid cycles counted in last/current run
//  done           out  1                          one-cycle pulse: run finished normally
//  error          out  1                          sticky: bad level or timeout; cleared by reset only
// BEHAVIOUR
//  Reset: FSM=IDLE. base, stride, num_iter, addr_count = 0. start_loop, in_nested_loop,
//   done, error = 0. cfg_ready = 1.
//  States:
//   IDLE:  cfg_ready=1. Config ops update registers the cycle after the handshake.
//          START -> S_START.
//   S_START: start_loop=1 for exactly one cycle; in_nested_loop=1; addr_count<=0;
//          watchdog<=0. Next state is RUN.
//   RUN:   in_nested_loop=1. addr_count++ on each cycle address_valid=1, saturating at
//          all-ones. watchdog++ each cycle.
//          loop_done=1 -> DONE, checked first (watchdog ignored on that cycle).
//          Else watchdog==TIMEOUT_CYCLES-1 -> error<=1, DONE.
//          loop_done is sampled only from the 2nd RUN cycle onward, so a stale done
//          level left from the previous run is ignored.
//   DONE:  done=1 for exactly one cycle; in_nested_loop=0 -> IDLE.
//  cfg_ready=0 in S_START/RUN/DONE. Ops offered then are held off, not dropped.
//  Config registers persist across runs; START reuses the last values.
//  cfg_level >= NUM_MAX_LOOPS on SET_ITER/SET_STRIDE: no register write, error<=1,
//   op still consumed.
//  num_iter=0 is forwarded unchanged; the generator treats it as one iteration.
//  Latency: START handshake at cycle t -> start_loop at t+1 -> RUN from t+2.
//  Outputs to the generator are registered: no combinational path cfg_* -> base/stride/num_iter.
//  Reset mid-run: returns to IDLE next cycle, all outputs to reset values, no done pulse.
// TESTING
//  1 Reset, then SET_BASE 0x100 -> base=0x100 one cycle after handshake; other fields stay 0.
//  2 SET_ITER L6=4, L5=3; SET_STRIDE L6=1, L5=16; START; model generator asserts
//    address_valid 12 cycles, then loop_done -> start_loop single pulse at t+1,
//    addr_count=12, done single pulse, cfg_ready returns 1.
//  3 SET_ITER with cfg_level=7 (NUM_MAX_LOOPS=7) -> num_iter unchanged, error=1 and
//    stays 1 through a following normal run.
//  4 TIMEOUT_CYCLES=16, START, loop_done never asserted -> error=1 and done pulse
//    16 cycles after entering RUN.
//  5 Hold cfg_valid with SET_BASE 0x200 during RUN -> cfg_ready=0, base unchanged;
//    op accepted in the first IDLE cycle after done.
//  6 Assert reset in the 5th RUN cycle -> next cycle in_nested_loop=0, registers=0,
//    no done pulse; a subsequent START runs normally.

Source files
------------

// File: rtl/nested_loop_cfg_ctrl.sv
// Loop-config front end for the SIMD nested-loop address generator: config regs, start/run/done sequencing, watchdog.
// Latency: config op visible one cycle after handshake; START at t -> start_loop at t+1 -> RUN from t+2.
// Backpressure: cfg_ready low outside IDLE, so offered ops are held off until the run completes.
module nested_loop_cfg_ctrl #(
    parameter int NUM_MAX_LOOPS     = 7,
    parameter int LOG_NUM_MAX_LOOPS = 3,
    parameter int BASE_WIDTH        = 32,
    parameter int STRIDE_WIDTH      = 32,
    parameter int NUM_ITER_WIDTH    = 32,
    parameter int TIMEOUT_CYCLES    = 1048576
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    cfg_valid,
    output logic                                    cfg_ready,
    input  logic [1:0]                              cfg_op,
    input  logic [LOG_NUM_MAX_LOOPS-1:0]            cfg_level,
    input  logic [BASE_WIDTH-1:0]                   cfg_value,
    output logic [BASE_WIDTH-1:0]                   base,
    output logic [STRIDE_WIDTH*NUM_MAX_LOOPS-1:0]   stride,
    output logic [NUM_ITER_WIDTH*NUM_MAX_LOOPS-1:0] num_iter,
    output logic                                    start_loop,
    output logic                                    in_nested_loop,
    input  logic                                    address_valid,
    input  logic                                    loop_done,
    output logic [NUM_ITER_WIDTH-1:0]               addr_count,
    output logic                                    done,
    output logic                                    error
);

    localparam logic [1:0] OP_SET_BASE   = 2'd0;
    localparam logic [1:0] OP_SET_ITER   = 2'd1;
    localparam logic [1:0] OP_SET_STRIDE = 2'd2;
    localparam logic [1:0] OP_START      = 2'd3;

    localparam int LVL_W = LOG_NUM_MAX_LOOPS + 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, S_START, RUN, DONE} state_t;

    state_t                                         state, state_nxt;
    logic [BASE_WIDTH-1:0]                          base_q;
    logic [NUM_MAX_LOOPS-1:0][STRIDE_WIDTH-1:0]     stride_q;
    logic [NUM_MAX_LOOPS-1:0][NUM_ITER_WIDTH-1:0]   iter_q;
    logic [NUM_ITER_WIDTH-1:0]                      cnt_q;
    logic [WD_W-1:0]                                wd_q;
    logic                                           error_q;

    logic cfg_fire;
    logic level_ok;
    logic done_seen;
    logic timeout_hit;

    assign cfg_fire = cfg_valid && cfg_ready;
    // Zero-extend so a power-of-two level count cannot wrap the bound to zero.
    assign level_ok = ({1'b0, cfg_level} < LVL_W'(NUM_MAX_LOOPS));
    // wd_q is zero only in the first RUN cycle, which masks a stale done level.
    assign done_seen   = loop_done && (wd_q != '0);
    assign timeout_hit = !done_seen && (wd_q == WD_LAST);

    assign base       = base_q;
    assign stride     = stride_q;
    assign num_iter   = iter_q;
    assign addr_count = cnt_q;
    assign error      = error_q;

    always_comb begin
        state_nxt      = state;
        cfg_ready      = 1'b0;
        start_loop     = 1'b0;
        in_nested_loop = 1'b0;
        done           = 1'b0;
        case (state)
            IDLE: begin
                cfg_ready = 1'b1;
                if (cfg_valid && (cfg_op == OP_START))
                    state_nxt = S_START;
            end
            S_START: begin
                start_loop     = 1'b1;
                in_nested_loop = 1'b1;
                state_nxt      = RUN;
            end
            RUN: begin
                in_nested_loop = 1'b1;
                if (done_seen || timeout_hit)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            base_q   <= '0;
            stride_q <= '0;
            iter_q   <= '0;
            cnt_q    <= '0;
            wd_q     <= '0;
            error_q  <= 1'b0;
        end else begin
            state <= state_nxt;

            if (cfg_fire) begin
                case (cfg_op)
                    OP_SET_BASE: base_q <= cfg_value;
                    OP_SET_ITER, OP_SET_STRIDE: begin
                        if (!level_ok)
                            error_q <= 1'b1;
                        for (int i = 0; i < NUM_MAX_LOOPS; i++) begin
                            if ({1'b0, cfg_level} == LVL_W'(i)) begin
                                if (cfg_op == OP_SET_ITER)
                                    iter_q[i] <= NUM_ITER_WIDTH'(cfg_value);
                                else
                                    stride_q[i] <= STRIDE_WIDTH'(cfg_value);
                            end
                        end
                    end
                    OP_START: ;
                    default: ;
                endcase
            end

            if (state == S_START) begin
                cnt_q <= '0;
                wd_q  <= '0;
            end

            if (state == RUN) begin
                wd_q <= wd_q + WD_W'(1);
                if (address_valid && (cnt_q != '1))
                    cnt_q <= cnt_q + NUM_ITER_WIDTH'(1);
                if (timeout_hit)
                    error_q <= 1'b1;
            end
        end
    end

endmodule
